// File: rtl/avalon_csr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_csr_pkg
//  Description : Shared types and constants for the Avalon-MM CSR master.
//                Holds the controller state encoding, the CSR data width and
//                the default CSR word-address width.
//  Revision    : 1.0 - initial release
// ============================================================================
package avalon_csr_pkg;

  localparam int CSR_DATA_W     = 32;
  localparam int DEFAULT_ADDR_W = 2;

  // Controller states; at most one transfer is ever in flight.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,  // waiting for a command
    ST_REQ      = 2'd1,  // strobe asserted, waiting for waitrequest low
    ST_WAIT_RDV = 2'd2,  // read accepted, waiting for readdatavalid
    ST_RESP     = 2'd3   // response presented, waiting for rsp_ready
  } state_e;

endpackage : avalon_csr_pkg
`default_nettype wire

// File: rtl/avalon_csr_master.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_csr_master
//  Description : Single-outstanding Avalon-MM master for a small CSR space.
//                Takes read/write commands on a valid/ready port, runs one
//                Avalon-MM transfer with a timeout watchdog and returns the
//                result on a valid/ready response port.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk                sole clock, rising edge
//    reset_n            asynchronous active-low reset
//    cmd_valid/ready    command handshake (ready only in IDLE)
//    cmd_write          1 = write, 0 = read
//    cmd_address        CSR word address
//    cmd_writedata      write data
//    rsp_valid/ready    response handshake
//    rsp_readdata       read data (0 for writes and aborted transfers)
//    rsp_error          transfer aborted by timeout
//    csr_*              Avalon-MM master signals (all outputs registered)
// ============================================================================
module avalon_csr_master
  import avalon_csr_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = DEFAULT_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_address,
  input  logic [CSR_DATA_W-1:0] cmd_writedata,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [CSR_DATA_W-1:0] rsp_readdata,
  output logic                  rsp_error,
  // Avalon-MM master
  output logic [ADDR_W-1:0]     csr_address,
  output logic                  csr_read,
  output logic                  csr_write,
  output logic [CSR_DATA_W-1:0] csr_writedata,
  input  logic                  csr_waitrequest,
  input  logic [CSR_DATA_W-1:0] csr_readdata,
  input  logic                  csr_readdatavalid
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e                  state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_error_q, rsp_error_d;
  logic [CSR_DATA_W-1:0]   rsp_readdata_q, rsp_readdata_d;
  logic                    csr_read_q, csr_read_d;
  logic                    csr_write_q, csr_write_d;
  logic [ADDR_W-1:0]       csr_address_q, csr_address_d;
  logic [CSR_DATA_W-1:0]   csr_writedata_q, csr_writedata_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    w_cmd_accept;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic                    w_timeout;

  // cmd_ready_q is only ever set while heading into IDLE, so it implies IDLE;
  // the state term keeps the accept decode self-evidently safe.
  assign w_cmd_accept = cmd_valid && cmd_ready_q && (state_q == ST_IDLE);
  assign w_cnt_inc    = cnt_q + CNT_W'(1);
  // Abort when this wait cycle would bring the count to the limit. Any
  // completion seen in the same cycle takes priority below.
  assign w_timeout    = (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      cmd_ready_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_error_q     <= 1'b0;
      rsp_readdata_q  <= '0;
      csr_read_q      <= 1'b0;
      csr_write_q     <= 1'b0;
      csr_address_q   <= '0;
      csr_writedata_q <= '0;
      cnt_q           <= '0;
    end else begin
      state_q         <= state_d;
      cmd_ready_q     <= cmd_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_error_q     <= rsp_error_d;
      rsp_readdata_q  <= rsp_readdata_d;
      csr_read_q      <= csr_read_d;
      csr_write_q     <= csr_write_d;
      csr_address_q   <= csr_address_d;
      csr_writedata_q <= csr_writedata_d;
      cnt_q           <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_cmd_accept) state_d = ST_REQ;
      end
      ST_REQ: begin
        // The strobe is always high in REQ, so waitrequest low means accepted.
        if (!csr_waitrequest) state_d = csr_write_q ? ST_RESP : ST_WAIT_RDV;
        else if (w_timeout)   state_d = ST_RESP;
      end
      ST_WAIT_RDV: begin
        if (csr_readdatavalid || w_timeout) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    // Ready is registered from the next state so it cannot rise in the cycle
    // rsp_ready is sampled, nor in the first cycle after reset release.
    cmd_ready_d     = (state_d == ST_IDLE);
    rsp_valid_d     = rsp_valid_q;
    rsp_error_d     = rsp_error_q;
    rsp_readdata_d  = rsp_readdata_q;
    csr_read_d      = csr_read_q;
    csr_write_d     = csr_write_q;
    csr_address_d   = csr_address_q;
    csr_writedata_d = csr_writedata_q;
    cnt_d           = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (w_cmd_accept) begin
          csr_read_d      = !cmd_write;
          csr_write_d     = cmd_write;
          csr_address_d   = cmd_address;
          csr_writedata_d = cmd_writedata;
          cnt_d           = '0;
        end
      end
      ST_REQ: begin
        cnt_d = w_cnt_inc;
        if (!csr_waitrequest) begin
          csr_read_d  = 1'b0;
          csr_write_d = 1'b0;
          if (csr_write_q) begin
            rsp_valid_d    = 1'b1;
            rsp_error_d    = 1'b0;
            rsp_readdata_d = '0;
          end
        end else if (w_timeout) begin
          csr_read_d     = 1'b0;
          csr_write_d    = 1'b0;
          rsp_valid_d    = 1'b1;
          rsp_error_d    = 1'b1;
          rsp_readdata_d = '0;
        end
      end
      ST_WAIT_RDV: begin
        cnt_d = w_cnt_inc;
        if (csr_readdatavalid) begin
          rsp_valid_d    = 1'b1;
          rsp_error_d    = 1'b0;
          rsp_readdata_d = csr_readdata;
        end else if (w_timeout) begin
          rsp_valid_d    = 1'b1;
          rsp_error_d    = 1'b1;
          rsp_readdata_d = '0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d    = 1'b0;
          rsp_error_d    = 1'b0;
          rsp_readdata_d = '0;
        end
      end
      default: ;
    endcase
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_error     = rsp_error_q;
  assign rsp_readdata  = rsp_readdata_q;
  assign csr_read      = csr_read_q;
  assign csr_write     = csr_write_q;
  assign csr_address   = csr_address_q;
  assign csr_writedata = csr_writedata_q;

endmodule : avalon_csr_master
`default_nettype wire
